inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Consumer side of the PC interface. Accepts fetch addresses from the PC unit, reads the
//  instruction memory over a req/gnt/rvalid handshake, and buffers {pc,instr} pairs in a FIFO
//  for decode. flush discards everything buffered or in flight on a taken/unconditional branch.
//  Sits between PC_unit and the decode/control stage.
// PARAMETERS
//  ADDR_W      32  PC / memory address width
//  INSTR_W     32  instruction width
//  FIFO_DEPTH  4   buffered entries; power of 2, >=2
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        synchronous, active-high
//  pc_in        in   ADDR_W   fetch address from PC unit
//  pc_valid     in   1        pc_in valid
//  pc_ready     out  1        fetch accepted when pc_valid & pc_ready
//  flush        in   1        branch redirect; discards FIFO and in-flight fetch
//  imem_req     out  1        memory request, held until imem_gnt
//  imem_addr    out  ADDR_W   word-aligned request address
//  imem_gnt     in   1        request accepted this cycle
//  imem_rvalid  in   1        read data valid
//  imem_rdata   in   INSTR_W  read data
//  instr_out    out  INSTR_W  head-of-FIFO instruction
//  instr_pc     out  ADDR_W   address of instr_out
//  instr_valid  out  1        head valid
//  instr_ready  in   1        decode consumes head when instr_valid & instr_ready
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, imem_req=0, imem_addr=0, instr_valid=0, fifo_count=0,
//    instr_out/instr_pc=0. pc_ready=1 first cycle after reset release (flush low).
//  - One outstanding memory access. FSM:
//    IDLE: pc_ready = !flush & (fifo_count < FIFO_DEPTH). Accept -> REQ;
//          imem_addr <= {pc_in[ADDR_W-1:2],2'b00} (low bits dropped).
//    REQ:  imem_req=1, addr stable. gnt&!flush -> RESP; gnt&flush -> DISCARD;
//          !gnt&flush -> IDLE (request withdrawn next cycle).
//    RESP: rvalid&!flush -> push {aligned pc, rdata}, -> IDLE; rvalid&flush -> drop, IDLE;
//          !rvalid&flush -> DISCARD.
//    DISCARD: wait rvalid, drop data, -> IDLE; flush ignored.
//    pc_ready=0 in REQ/RESP/DISCARD. imem_rvalid ignored in IDLE and REQ.
//  - Space reserved at accept: push never sees a full FIFO; no overflow path.
//  - Latency: accept in cycle N -> imem_req=1 in N+1. rvalid in M -> instr_valid=1 in M+1
//    when FIFO was empty (no bypass).
//  - Output: instr_valid = (fifo_count!=0) & !flush (combinational gate). A valid&ready in a
//    flush cycle is void. Flush empties FIFO; fifo_count=0 next cycle.
//  - Push and pop in the same cycle: count unchanged; read/write pointers wrap modulo
//    FIFO_DEPTH, occupancy held in a separate counter.
//  - Reset mid-operation: all in-flight state lost; a late rvalid after reset lands in IDLE
//    and is ignored.
// STRUCTURE
//  - Package cpu_fetch_pkg: fetch FSM state encoding (IDLE/REQ/RESP/DISCARD), ADDR_W/INSTR_W
//    defaults, NOP instruction constant.
//  - Sub-module fetch_fifo: sync FIFO, width ADDR_W+INSTR_W, depth FIFO_DEPTH; push/pop/clear,
//    count output. FSM and memory handshake stay in inst_fetch_unit.
// TESTING
//  1. Reset; pc_in=0x00000000 accepted; gnt with req; rvalid 2 cyc later, rdata=0x8B020020
//     -> next cycle instr_valid=1, instr_pc=0x00000000, instr_out=0x8B020020.
//  2. instr_ready=0; fetch 0x0,0x4,0x8,0xC -> fifo_count=4, pc_ready=0; one pop -> pc_ready=1
//     next cycle, then fetch 0x10 accepted.
//  3. Flush the cycle after gnt; rvalid 3 cyc later -> state DISCARD, pc_ready=0 until
//     rvalid, no push, fifo_count stays 0.
//  4. FIFO holds 3, flush with instr_ready=1 -> instr_valid=0 that cycle, fifo_count=0 next.
//  5. pc_in=0x00000006 -> imem_addr=0x00000004, instr_pc=0x00000004.
//  6. Reset asserted in RESP -> next cycle imem_req=0, fifo_count=0; stale rvalid ignored.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: state encoding, default widths
// and the canonical NOP encoding used by the fetch/decode boundary.
package cpu_fetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RESP    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries between fetch and decode.
// Pointers wrap naturally (power-of-2 depth); occupancy is tracked in its own counter.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Callers reserve space before pushing, so push is never qualified by a full flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: accepts PCs, performs one outstanding imem read at a time and queues
// {pc, instr} pairs for decode; flush drops queued and in-flight fetches.
module inst_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [ADDR_W-1:0]           i_pc_in,
    input  logic                        i_pc_valid,
    output logic                        o_pc_ready,
    input  logic                        i_flush,
    output logic                        o_imem_req,
    output logic [ADDR_W-1:0]           o_imem_addr,
    input  logic                        i_imem_gnt,
    input  logic                        i_imem_rvalid,
    input  logic [INSTR_W-1:0]          i_imem_rdata,
    output logic [INSTR_W-1:0]          o_instr_out,
    output logic [ADDR_W-1:0]           o_instr_pc,
    output logic                        o_instr_valid,
    input  logic                        i_instr_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int                ENTRY_W    = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count;
    logic [ENTRY_W-1:0]  w_head;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DISCARD exists to swallow the one response already owed by memory after a flush.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_imem_gnt) begin
                    w_next_state = i_flush ? ST_DISCARD : ST_RESP;
                end else if (i_flush) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (i_imem_rvalid) begin
                    w_next_state = ST_IDLE;
                end else if (i_flush) begin
                    w_next_state = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (i_imem_rvalid) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pc_ready = 1'b0;
        o_imem_req = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            ST_IDLE: o_pc_ready = !i_flush && (w_count < DEPTH_C);
            ST_REQ:  o_imem_req = 1'b1;
            ST_RESP: w_push     = i_imem_rvalid && !i_flush;
            default: ;
        endcase
    end

    assign w_accept = i_pc_valid && o_pc_ready;

    // The masked address doubles as the pc stored alongside the returned instruction.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= i_pc_in & ALIGN_MASK;
        end
    end

    assign o_instr_valid = (w_count != '0) && !i_flush;
    assign w_pop         = o_instr_valid && i_instr_ready;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_addr, i_imem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign o_imem_addr  = r_addr;
    assign o_instr_pc   = w_head[ENTRY_W-1:INSTR_W];
    assign o_instr_out  = w_head[INSTR_W-1:0];
    assign o_fifo_count = w_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level model (queue + outstanding-access flags).
module tb_inst_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pcIn;
    logic        pcValid;
    logic        pcReady;
    logic        flush;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        instrReady;
    logic [2:0]  fifoCount;

    int checks = 0;
    int errors = 0;

    // Reference model: queued {pc, instr} pairs plus the status of the single memory access.
    logic [63:0] mQueue[$];
    bit          mBusy;
    bit          mGranted;
    bit          mDoomed;
    logic [31:0] mAddr;

    always #5 clock = ~clock;

    inst_fetch_unit #(
        .ADDR_W     (32),
        .INSTR_W    (32),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk         (clock),
        .i_reset       (reset),
        .i_pc_in       (pcIn),
        .i_pc_valid    (pcValid),
        .o_pc_ready    (pcReady),
        .i_flush       (flush),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_gnt    (imemGnt),
        .i_imem_rvalid (imemRvalid),
        .i_imem_rdata  (imemRdata),
        .o_instr_out   (instrOut),
        .o_instr_pc    (instrPc),
        .o_instr_valid (instrValid),
        .i_instr_ready (instrReady),
        .o_fifo_count  (fifoCount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("pc_ready", 64'(pcReady), 64'(!mBusy && !flush && (mQueue.size() < 4)));
        checkOutput("imem_req", 64'(imemReq), 64'(mBusy && !mGranted));
        checkOutput("imem_addr", 64'(imemAddr), 64'(mAddr));
        checkOutput("instr_valid", 64'(instrValid), 64'((mQueue.size() != 0) && !flush));
        checkOutput("fifo_count", 64'(fifoCount), 64'(mQueue.size()));
        if (mQueue.size() != 0) begin
            checkOutput("head", {instrPc, instrOut}, mQueue[0]);
        end
    endtask

    task automatic updateModel(input logic rst, input logic pv, input logic [31:0] pc,
                               input logic fl, input logic gnt, input logic rv,
                               input logic [31:0] rd, input logic rdy);
        bit accepted;
        bit popped;
        if (rst) begin
            mQueue.delete();
            mBusy    = 0;
            mGranted = 0;
            mDoomed  = 0;
            mAddr    = '0;
            return;
        end
        accepted = !mBusy && !fl && (mQueue.size() < 4) && pv;
        popped   = (mQueue.size() != 0) && !fl && rdy;
        if (fl) begin
            mQueue.delete();
        end else if (popped) begin
            void'(mQueue.pop_front());
        end
        if (!mBusy) begin
            if (accepted) begin
                mBusy    = 1;
                mGranted = 0;
                mDoomed  = 0;
                mAddr    = {pc[31:2], 2'b00};
            end
        end else if (!mGranted) begin
            if (gnt) begin
                mGranted = 1;
                mDoomed  = fl;
            end else if (fl) begin
                mBusy = 0;
            end
        end else begin
            if (rv) begin
                if (!mDoomed && !fl) begin
                    mQueue.push_back({mAddr, rd});
                end
                mBusy    = 0;
                mGranted = 0;
                mDoomed  = 0;
            end else if (fl) begin
                mDoomed = 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic pv, input logic [31:0] pc,
                                 input logic fl, input logic gnt, input logic rv,
                                 input logic [31:0] rd, input logic rdy);
        @(negedge clock);
        reset      = rst;
        pcValid    = pv;
        pcIn       = pc;
        flush      = fl;
        imemGnt    = gnt;
        imemRvalid = rv;
        imemRdata  = rd;
        instrReady = rdy;
        #1;
        compareModel();
        @(posedge clock);
        updateModel(rst, pv, pc, fl, gnt, rv, rd, rdy);
    endtask

    task automatic fetchOne(input logic [31:0] pc, input logic [31:0] data);
        applyStimulus(0, 1, pc, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1; pcIn = '0; pcValid = 0; flush = 0;
        imemGnt = 0; imemRvalid = 0; imemRdata = '0; instrReady = 0;
        repeat (2) @(posedge clock);
        updateModel(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
        @(negedge clock);
        checkOutput("rst_req", 64'(imemReq), 64'(0));
        checkOutput("rst_addr", 64'(imemAddr), 64'(0));
        checkOutput("rst_valid", 64'(instrValid), 64'(0));
        checkOutput("rst_count", 64'(fifoCount), 64'(0));
        checkOutput("rst_instr", {instrPc, instrOut}, 64'(0));

        $display("[TB] scenario 1: basic fetch");
        applyStimulus(0, 1, 32'h0, 0, 0, 0, 32'h0, 0);
        #1 checkOutput("t1_req", 64'(imemReq), 64'(1));
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h8B020020, 0);
        #1;
        checkOutput("t1_valid", 64'(instrValid), 64'(1));
        checkOutput("t1_pc", 64'(instrPc), 64'h0);
        checkOutput("t1_instr", 64'(instrOut), 64'h8B020020);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 1);

        $display("[TB] scenario 2: fill FIFO");
        for (int i = 0; i < 4; i++) begin
            fetchOne(32'(i * 4), 32'hA000_0000 + 32'(i));
        end
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 32'h0, 0);
        checkOutput("t2_count", 64'(fifoCount), 64'(4));
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0, 1);
        #1 checkOutput("t2_ready", 64'(pcReady), 64'(1));
        fetchOne(32'h10, 32'hA000_0010);
        #1 checkOutput("t2_count4", 64'(fifoCount), 64'(4));

        $display("[TB] scenario 3: flush after grant");
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h20, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h24, 0, 0, 0, 32'h0, 0);
        #1 checkOutput("t3_busy", 64'(pcReady), 64'(0));
        applyStimulus(0, 1, 32'h24, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        #1;
        checkOutput("t3_count", 64'(fifoCount), 64'(0));
        checkOutput("t3_ready", 64'(pcReady), 64'(1));

        $display("[TB] scenario 4: flush with three queued");
        for (int i = 0; i < 3; i++) begin
            fetchOne(32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i));
        end
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0, 1);
        #1 checkOutput("t4_count", 64'(fifoCount), 64'(0));

        $display("[TB] scenario 5: unaligned pc");
        applyStimulus(0, 1, 32'h6, 0, 0, 0, 32'h0, 0);
        #1 checkOutput("t5_addr", 64'(imemAddr), 64'h4);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h1234_5678, 0);
        #1 checkOutput("t5_pc", 64'(instrPc), 64'h4);

        $display("[TB] scenario 6: reset during response wait");
        applyStimulus(0, 1, 32'h80, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
        #1;
        checkOutput("t6_req", 64'(imemReq), 64'(0));
        checkOutput("t6_count", 64'(fifoCount), 64'(0));
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 0);
        #1 checkOutput("t6_stale", 64'(fifoCount), 64'(0));

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(9) < 7),
                          $urandom,
                          ($urandom_range(9) == 0),
                          ($urandom_range(1) == 1),
                          ($urandom_range(2) == 0),
                          $urandom,
                          ($urandom_range(1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
